fpga_bram_ctrl: RTL and testbench
=================================

// Module: fpga_bram_ctrl
// PURPOSE
// - Sequencer and arbiter for the FPGA BRAM multiplexed address/data bus.
// - Shares one BRAM port between NUM_REQ requesters (e.g. core I-side and D-side) with round-robin arbitration.
// - Converts each simple valid/ready request into the bus protocol: address phase, optional write-data phase, wait for resp.
// - Returns read data, or an error on timeout.
// PARAMETERS
// ADDR_WIDTH   32    request address width; zero-extended onto the bus in the address phase
// DATA_WIDTH   64    bus and data width (>= ADDR_WIDTH)
// NUM_REQ      2     number of requesters (>= 2)
// TIMEOUT      255   max cycles waiting for mem_resp before error (>= 1)
// PORTS
// clk                 in   1                     clock
// rst                 in   1                     asynchronous, active-low reset
// req_valid           in   NUM_REQ               requester i has a pending request
// req_ready           out  NUM_REQ               one-hot pulse: request i accepted this cycle
// req_we              in   NUM_REQ               1 = write, 0 = read
// req_addr            in   NUM_REQ x ADDR_WIDTH  request address
// req_wdata           in   NUM_REQ x DATA_WIDTH  write data
// rsp_valid           out  NUM_REQ               one-hot pulse: transaction for i complete
// rsp_rdata           out  DATA_WIDTH            read data; valid with rsp_valid
// rsp_err             out  1                     timeout flag; valid with rsp_valid
// mem_adb_o           out  DATA_WIDTH            drives BRAM address_data_bus_i
// mem_address_on      out  1                     address phase strobe
// mem_data_on         out  1                     write-data phase strobe
// mem_read_en         out  1                     read transaction in progress
// mem_write_en        out  1                     write transaction in progress
// mem_adb_i           in   DATA_WIDTH            from BRAM address_data_bus_o
// mem_resp            in   1                     BRAM completion pulse
// BEHAVIOUR
// - Reset (rst=0, async): state IDLE, rr pointer = 0, timeout counter = 0, all outputs 0.
//   Reset mid-transaction drops the transaction; no rsp_valid is issued.
// - States:
//   - IDLE: if any req_valid, grant the first set bit at or after rr pointer (wrapping).
//     Assert req_ready[g] combinationally that cycle. Latch g, we, addr, wdata.
//     rr pointer <= (g+1) mod NUM_REQ. Next state ADDR.
//   - ADDR (1 cycle): mem_address_on=1; mem_adb_o = zero-extended addr.
//     mem_read_en = ~we, mem_write_en = we. Next state WDATA if we, else WAIT.
//   - WDATA (1 cycle): mem_data_on=1, mem_adb_o = wdata, mem_write_en=1. Next state WAIT.
//   - WAIT: hold mem_read_en/mem_write_en; mem_adb_o=0; count cycles.
//     - mem_resp=1: capture mem_adb_i (reads) into rsp_rdata; go to RESP, err=0.
//     - Count reaches TIMEOUT without resp: rsp_rdata=0, err=1, go to RESP.
//     - If mem_resp and timeout coincide, resp wins (err=0).
//   - RESP (1 cycle): rsp_valid[g]=1; rsp_err per WAIT result.
//     rsp_rdata holds the captured value until the next capture (0 for writes).
//     Next state IDLE; no back-to-back grant in RESP.
// - Latency, accept -> rsp_valid (resp after k WAIT cycles, k>=1): read = 2+k cycles, write = 3+k cycles.
// - Only one outstanding transaction. mem_resp outside WAIT is ignored.
// - mem_address_on and mem_data_on are never both 1.
// - Requesters must hold req_* stable until req_ready.
// - Timeout counter width: $clog2(TIMEOUT+1); it clears on entry to WAIT.
// STRUCTURE
// - Package fpga_bram_pkg:
//   - state enum bram_ctrl_state_e {IDLE, ADDR, WDATA, WAIT, RESP}
//   - BRAM_ADDR_WIDTH / BRAM_DATA_WIDTH default constants
// - Sub-module rr_arbiter #(N): inputs req[N] and ptr; outputs one-hot gnt[N] and gnt_idx.
// - FSM, latches and timeout counter live in fpga_bram_ctrl.
// TESTING
// 1. Read, req0 addr=0x100, mem_resp 3 cycles after ADDR with mem_adb_i=0xDEADBEEF_CAFEF00D
//    -> ADDR bus=0x100, read_en=1; rsp_valid[0] with that data, err=0.
// 2. Write, req1 addr=0x20, wdata=0x1122334455667788
//    -> ADDR then WDATA (data_on=1, bus=wdata, write_en=1); rsp_valid[1] after resp.
// 3. req0 and req1 both valid continuously, 4 reads
//    -> grants alternate 0,1,0,1; no starvation.
// 4. Read, mem_resp never asserted, TIMEOUT=255
//    -> rsp_valid[0] with err=1 and rdata=0 at 255 WAIT cycles.
// 5. Mem_resp on the exact timeout cycle
//    -> err=0, data captured.
// 6. Assert rst during WAIT
//    -> all outputs 0 immediately; no rsp_valid.
//    Next request is granted to req0 (rr=0) and completes normally.

Source files
------------

// File: rtl/fpga_bram_pkg.sv
// Shared types and default widths for the BRAM multiplexed-bus controller.
package fpga_bram_pkg;

  localparam int BRAM_ADDR_WIDTH = 32;
  localparam int BRAM_DATA_WIDTH = 64;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    WDATA,
    WAIT,
    RESP
  } bram_ctrl_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after ptr, wrapping.
module rr_arbiter
  import fpga_bram_pkg::*;
#(
  parameter  int N  = 2,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx
);

  localparam int unsigned NU = N;

  int unsigned   idx;
  logic [IW-1:0] sel;
  logic          found;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
    sel     = '0;
    for (int unsigned i = 0; i < NU; i++) begin
      // Wrap in full int width so non-power-of-two N stays correct.
      idx = 32'(ptr) + i;
      if (idx >= NU) idx = idx - NU;
      sel = IW'(idx);
      if (!found && req[sel]) begin
        found    = 1'b1;
        gnt[sel] = 1'b1;
        gnt_idx  = sel;
      end
    end
  end

endmodule

// File: rtl/fpga_bram_ctrl.sv
// Arbitrates NUM_REQ requesters onto one BRAM multiplexed address/data port
// and sequences the address, write-data and response-wait phases.
module fpga_bram_ctrl
  import fpga_bram_pkg::*;
#(
  parameter int ADDR_WIDTH = BRAM_ADDR_WIDTH,
  parameter int DATA_WIDTH = BRAM_DATA_WIDTH,
  parameter int NUM_REQ    = 2,
  parameter int TIMEOUT    = 255
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NUM_REQ-1:0]                   req_valid,
  output logic [NUM_REQ-1:0]                   req_ready,
  input  logic [NUM_REQ-1:0]                   req_we,
  input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]   req_addr,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]                   rsp_valid,
  output logic [DATA_WIDTH-1:0]                rsp_rdata,
  output logic                                 rsp_err,
  output logic [DATA_WIDTH-1:0]                mem_adb_o,
  output logic                                 mem_address_on,
  output logic                                 mem_data_on,
  output logic                                 mem_read_en,
  output logic                                 mem_write_en,
  input  logic [DATA_WIDTH-1:0]                mem_adb_i,
  input  logic                                 mem_resp
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(TIMEOUT + 1);

  bram_ctrl_state_e      state;
  logic [IW-1:0]         rr_ptr;
  logic [CW-1:0]         cnt;
  logic [IW-1:0]         lat_g;
  logic                  lat_we;
  logic [ADDR_WIDTH-1:0] lat_addr;
  logic [DATA_WIDTH-1:0] lat_wdata;

  logic [NUM_REQ-1:0]    gnt;
  logic [IW-1:0]         gnt_idx;
  logic                  cnt_done;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req     (req_valid),
    .ptr     (rr_ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  // cnt counts completed WAIT cycles, so TIMEOUT-1 marks the last WAIT cycle.
  assign cnt_done = (cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      cnt       <= '0;
      lat_g     <= '0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|req_valid) begin
            lat_g     <= gnt_idx;
            lat_we    <= req_we[gnt_idx];
            lat_addr  <= req_addr[gnt_idx];
            lat_wdata <= req_wdata[gnt_idx];
            rr_ptr    <= (gnt_idx == IW'(NUM_REQ - 1)) ? '0 : gnt_idx + IW'(1);
            state     <= ADDR;
          end
        end
        ADDR: begin
          cnt   <= '0;
          state <= lat_we ? WDATA : WAIT;
        end
        WDATA: begin
          cnt   <= '0;
          state <= WAIT;
        end
        WAIT: begin
          if (mem_resp) begin
            rsp_rdata <= lat_we ? '0 : mem_adb_i;
            rsp_err   <= 1'b0;
            state     <= RESP;
          end else if (cnt_done) begin
            rsp_rdata <= '0;
            rsp_err   <= 1'b1;
            state     <= RESP;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    req_ready      = '0;
    rsp_valid      = '0;
    mem_adb_o      = '0;
    mem_address_on = 1'b0;
    mem_data_on    = 1'b0;
    mem_read_en    = 1'b0;
    mem_write_en   = 1'b0;
    case (state)
      IDLE: if (rst) req_ready = gnt;
      ADDR: begin
        mem_address_on = 1'b1;
        mem_adb_o      = DATA_WIDTH'(lat_addr);
        mem_read_en    = ~lat_we;
        mem_write_en   = lat_we;
      end
      WDATA: begin
        mem_data_on  = 1'b1;
        mem_adb_o    = lat_wdata;
        mem_write_en = 1'b1;
      end
      WAIT: begin
        mem_read_en  = ~lat_we;
        mem_write_en = lat_we;
      end
      RESP:    rsp_valid[lat_g] = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_fpga_bram_ctrl.sv
// Self-checking bench for fpga_bram_ctrl against a transaction-level model.
module tb_fpga_bram_ctrl;

  localparam int AW = 32;
  localparam int DW = 64;
  localparam int NR = 2;
  localparam int TO = 255;

  logic                   clk = 1'b0;
  logic                   rst = 1'b0;
  logic [NR-1:0]          req_valid = '0;
  logic [NR-1:0]          req_ready;
  logic [NR-1:0]          req_we = '0;
  logic [NR-1:0][AW-1:0]  req_addr = '0;
  logic [NR-1:0][DW-1:0]  req_wdata = '0;
  logic [NR-1:0]          rsp_valid;
  logic [DW-1:0]          rsp_rdata;
  logic                   rsp_err;
  logic [DW-1:0]          mem_adb_o;
  logic                   mem_address_on;
  logic                   mem_data_on;
  logic                   mem_read_en;
  logic                   mem_write_en;
  logic [DW-1:0]          mem_adb_i = '0;
  logic                   mem_resp = 1'b0;

  fpga_bram_ctrl #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .NUM_REQ    (NR),
    .TIMEOUT    (TO)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_we         (req_we),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .rsp_valid      (rsp_valid),
    .rsp_rdata      (rsp_rdata),
    .rsp_err        (rsp_err),
    .mem_adb_o      (mem_adb_o),
    .mem_address_on (mem_address_on),
    .mem_data_on    (mem_data_on),
    .mem_read_en    (mem_read_en),
    .mem_write_en   (mem_write_en),
    .mem_adb_i      (mem_adb_i),
    .mem_resp       (mem_resp)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int model_ptr = 0;

  logic [NR-1:0] o_gnt, o_rsp;
  logic [DW-1:0] o_abus, o_dbus, o_rdata;
  logic          o_aon, o_ren, o_wen, o_don, o_daon, o_dwen, o_both, o_err;
  int            o_lat;

  function automatic int exp_grant(input logic [NR-1:0] v);
    int idx;
    for (int i = 0; i < NR; i++) begin
      idx = (model_ptr + i) % NR;
      if (((v >> idx) & 2'b01) != 0) return idx;
    end
    return 0;
  endfunction

  // Drives one request and records what the bus did; k = WAIT cycle carrying
  // mem_resp (0 = never), stray = spurious mem_resp during the address phase.
  task automatic run_txn(input logic [NR-1:0] v, input logic [NR-1:0] we,
                         input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                         input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                         input int k, input logic [DW-1:0] rd, input bit stray);
    int n;
    int resp_t;
    bit w;
    req_valid = v; req_we = we;
    req_addr[0] = a0; req_addr[1] = a1; req_wdata[0] = d0; req_wdata[1] = d1;
    o_lat = -1; o_both = 1'b0; o_rsp = '0; o_rdata = '0; o_err = 1'b0;
    o_abus = '0; o_dbus = '0; o_aon = 0; o_ren = 0; o_wen = 0; o_don = 0; o_daon = 0; o_dwen = 0;
    #1;
    n = 0;
    while (req_ready == '0 && n < 20) begin @(posedge clk); #1; n++; end
    o_gnt = req_ready;
    if (req_ready == '0) begin req_valid = '0; return; end
    w = o_gnt[1] ? we[1] : we[0];
    resp_t = (k > 0) ? (w ? 2 : 1) + k : -1;
    for (int t = 1; t <= 400; t++) begin
      @(posedge clk); #1;
      if (t == 1) req_valid = req_valid & ~o_gnt;
      mem_resp  = (t == resp_t) || (stray && t == 1);
      mem_adb_i = (t == resp_t) ? rd : {$urandom, $urandom};
      #1;
      if (mem_address_on && mem_data_on) o_both = 1'b1;
      if (t == 1) begin o_abus = mem_adb_o; o_aon = mem_address_on; o_ren = mem_read_en; o_wen = mem_write_en; end
      if (t == 2) begin o_dbus = mem_adb_o; o_don = mem_data_on; o_daon = mem_address_on; o_dwen = mem_write_en; end
      if (rsp_valid != '0) begin
        o_lat = t; o_rsp = rsp_valid; o_rdata = rsp_rdata; o_err = rsp_err;
        break;
      end
    end
    mem_resp = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; req_valid = 2'b11; req_we = 2'b01;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({req_ready, rsp_valid, rsp_rdata, rsp_err, mem_adb_o, mem_address_on, mem_data_on, mem_read_en, mem_write_en} !== '0) begin
      failures++; $display("FAIL reset_outputs got ready=%b rsp=%b rdata=%0h err=%b bus=%0h", req_ready, rsp_valid, rsp_rdata, rsp_err, mem_adb_o);
    end
    req_valid = '0; rst = 1'b1; model_ptr = 0;
    @(posedge clk); #1;
    checks++;
    if ({rsp_valid, mem_address_on, mem_read_en, mem_write_en} !== '0) begin
      failures++; $display("FAIL idle_after_reset got rsp=%b aon=%b ren=%b wen=%b exp 0", rsp_valid, mem_address_on, mem_read_en, mem_write_en);
    end
  endtask

  task automatic test_read();
    int g;
    g = exp_grant(2'b01);
    run_txn(2'b01, 2'b00, 32'h100, 32'h0, '0, '0, 3, 64'hDEADBEEF_CAFEF00D, 1'b0);
    model_ptr = (g + 1) % NR;
    checks++; if (o_gnt !== 2'(1 << g)) begin failures++; $display("FAIL rd_gnt got=%b exp=%b", o_gnt, 2'(1 << g)); end
    checks++; if (o_abus !== 64'h100 || o_aon !== 1'b1) begin failures++; $display("FAIL rd_addr got bus=%0h aon=%b exp bus=100 aon=1", o_abus, o_aon); end
    checks++; if (o_ren !== 1'b1 || o_wen !== 1'b0) begin failures++; $display("FAIL rd_en got ren=%b wen=%b exp ren=1 wen=0", o_ren, o_wen); end
    checks++; if (o_lat !== 5) begin failures++; $display("FAIL rd_latency got=%0d exp=5", o_lat); end
    checks++; if (o_rsp !== 2'b01) begin failures++; $display("FAIL rd_rsp_valid got=%b exp=01", o_rsp); end
    checks++; if (o_rdata !== 64'hDEADBEEF_CAFEF00D || o_err !== 1'b0) begin failures++; $display("FAIL rd_data got=%0h err=%b exp=deadbeefcafef00d err=0", o_rdata, o_err); end
  endtask

  task automatic test_write();
    int g, k;
    g = exp_grant(2'b10);
    k = $urandom_range(1, 5);
    run_txn(2'b10, 2'b10, '0, 32'h20, '0, 64'h1122334455667788, k, {$urandom, $urandom}, 1'b0);
    model_ptr = (g + 1) % NR;
    checks++; if (o_gnt !== 2'b10) begin failures++; $display("FAIL wr_gnt got=%b exp=10", o_gnt); end
    checks++; if (o_abus !== 64'h20 || o_aon !== 1'b1 || o_wen !== 1'b1 || o_ren !== 1'b0) begin
      failures++; $display("FAIL wr_addr got bus=%0h aon=%b wen=%b ren=%b exp bus=20 aon=1 wen=1 ren=0", o_abus, o_aon, o_wen, o_ren);
    end
    checks++; if (o_dbus !== 64'h1122334455667788 || o_don !== 1'b1 || o_daon !== 1'b0 || o_dwen !== 1'b1) begin
      failures++; $display("FAIL wr_data_phase got bus=%0h don=%b aon=%b wen=%b exp bus=1122334455667788 don=1 aon=0 wen=1", o_dbus, o_don, o_daon, o_dwen);
    end
    checks++; if (o_lat !== 3 + k) begin failures++; $display("FAIL wr_latency got=%0d exp=%0d", o_lat, 3 + k); end
    checks++; if (o_rsp !== 2'b10 || o_err !== 1'b0 || o_rdata !== '0) begin
      failures++; $display("FAIL wr_rsp got rsp=%b err=%b rdata=%0h exp rsp=10 err=0 rdata=0", o_rsp, o_err, o_rdata);
    end
  endtask

  task automatic test_back_to_back();
    int g, k;
    logic [DW-1:0] rd;
    logic [NR-1:0] prev;
    prev = '0;
    for (int i = 0; i < 4; i++) begin
      g = exp_grant(2'b11);
      k = $urandom_range(1, 4);
      rd = {$urandom, $urandom};
      run_txn(2'b11, 2'b00, $urandom, $urandom, '0, '0, k, rd, 1'b0);
      model_ptr = (g + 1) % NR;
      checks++; if (o_gnt !== 2'(1 << g) || o_gnt === prev) begin failures++; $display("FAIL b2b_gnt[%0d] got=%b exp=%b prev=%b", i, o_gnt, 2'(1 << g), prev); end
      checks++; if (o_lat !== 2 + k || o_rsp !== 2'(1 << g) || o_rdata !== rd) begin
        failures++; $display("FAIL b2b_rsp[%0d] got lat=%0d rsp=%b data=%0h exp lat=%0d rsp=%b data=%0h", i, o_lat, o_rsp, o_rdata, 2 + k, 2'(1 << g), rd);
      end
      prev = o_gnt;
    end
    req_valid = '0;
  endtask

  task automatic test_random();
    int g, k;
    bit w;
    logic [NR-1:0] v, we;
    logic [AW-1:0] a0, a1, ag;
    logic [DW-1:0] d0, d1, dg, rd, exp_rd;
    for (int i = 0; i < 12; i++) begin
      v = 2'($urandom_range(1, 3)); we = 2'($urandom_range(0, 3));
      a0 = $urandom; a1 = $urandom; d0 = {$urandom, $urandom}; d1 = {$urandom, $urandom};
      rd = {$urandom, $urandom}; k = $urandom_range(1, 8);
      g = exp_grant(v);
      w = (g == 1) ? we[1] : we[0];
      ag = (g == 1) ? a1 : a0;
      dg = (g == 1) ? d1 : d0;
      exp_rd = w ? '0 : rd;
      run_txn(v, we, a0, a1, d0, d1, k, rd, (i % 3) == 0);
      model_ptr = (g + 1) % NR;
      checks++; if (o_gnt !== 2'(1 << g)) begin failures++; $display("FAIL rnd_gnt[%0d] got=%b exp=%b", i, o_gnt, 2'(1 << g)); end
      checks++; if (o_abus !== DW'(ag) || o_ren !== !w || o_wen !== w) begin
        failures++; $display("FAIL rnd_addr[%0d] got bus=%0h ren=%b wen=%b exp bus=%0h ren=%b wen=%b", i, o_abus, o_ren, o_wen, DW'(ag), !w, w);
      end
      if (w) begin
        checks++; if (o_dbus !== dg || o_don !== 1'b1) begin failures++; $display("FAIL rnd_wdata[%0d] got bus=%0h don=%b exp bus=%0h don=1", i, o_dbus, o_don, dg); end
      end
      checks++; if (o_lat !== (w ? 3 : 2) + k) begin failures++; $display("FAIL rnd_latency[%0d] got=%0d exp=%0d", i, o_lat, (w ? 3 : 2) + k); end
      checks++; if (o_rsp !== 2'(1 << g) || o_rdata !== exp_rd || o_err !== 1'b0) begin
        failures++; $display("FAIL rnd_rsp[%0d] got rsp=%b data=%0h err=%b exp rsp=%b data=%0h err=0", i, o_rsp, o_rdata, o_err, 2'(1 << g), exp_rd);
      end
      checks++; if (o_both !== 1'b0) begin failures++; $display("FAIL rnd_strobe_overlap[%0d] got=1 exp=0", i); end
    end
  endtask

  task automatic test_timeout();
    int g;
    g = exp_grant(2'b01);
    run_txn(2'b01, 2'b00, 32'hABC, '0, '0, '0, 0, '0, 1'b0);
    model_ptr = (g + 1) % NR;
    checks++; if (o_lat !== 2 + TO) begin failures++; $display("FAIL to_latency got=%0d exp=%0d", o_lat, 2 + TO); end
    checks++; if (o_rsp !== 2'b01 || o_err !== 1'b1 || o_rdata !== '0) begin
      failures++; $display("FAIL to_rsp got rsp=%b err=%b data=%0h exp rsp=01 err=1 data=0", o_rsp, o_err, o_rdata);
    end
  endtask

  task automatic test_timeout_edge();
    int g;
    logic [DW-1:0] rd;
    rd = {$urandom | 32'h1, $urandom};
    g = exp_grant(2'b10);
    run_txn(2'b10, 2'b00, '0, 32'h55, '0, '0, TO, rd, 1'b0);
    model_ptr = (g + 1) % NR;
    checks++; if (o_lat !== 2 + TO) begin failures++; $display("FAIL edge_latency got=%0d exp=%0d", o_lat, 2 + TO); end
    checks++; if (o_rsp !== 2'b10 || o_err !== 1'b0 || o_rdata !== rd) begin
      failures++; $display("FAIL edge_rsp got rsp=%b err=%b data=%0h exp rsp=10 err=0 data=%0h", o_rsp, o_err, o_rdata, rd);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    bit seen;
    logic [DW-1:0] rd;
    req_valid = 2'b01; req_we = 2'b00; req_addr[0] = $urandom;
    #1;
    n = 0;
    while (req_ready == '0 && n < 20) begin @(posedge clk); #1; n++; end
    checks++; if (req_ready !== 2'b01) begin failures++; $display("FAIL rst_mid_accept got=%b exp=01", req_ready); end
    @(posedge clk); #1; req_valid = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++; if (mem_read_en !== 1'b1) begin failures++; $display("FAIL rst_mid_wait_read_en got=%b exp=1", mem_read_en); end
    #2; rst = 1'b0; #1;
    checks++;
    if ({req_ready, rsp_valid, rsp_rdata, rsp_err, mem_adb_o, mem_address_on, mem_data_on, mem_read_en, mem_write_en} !== '0) begin
      failures++; $display("FAIL rst_mid_outputs got rsp=%b ren=%b wen=%b bus=%0h rdata=%0h exp all 0", rsp_valid, mem_read_en, mem_write_en, mem_adb_o, rsp_rdata);
    end
    model_ptr = 0;
    seen = 1'b0;
    repeat (3) begin @(posedge clk); #1; if (rsp_valid != '0) seen = 1'b1; end
    rst = 1'b1;
    repeat (4) begin @(posedge clk); #1; if (rsp_valid != '0) seen = 1'b1; end
    checks++; if (seen !== 1'b0) begin failures++; $display("FAIL rst_mid_no_rsp got=1 exp=0"); end
    rd = {$urandom, $urandom};
    run_txn(2'b11, 2'b00, 32'h40, 32'h80, '0, '0, 2, rd, 1'b0);
    model_ptr = 1;
    req_valid = '0;
    checks++; if (o_gnt !== 2'b01) begin failures++; $display("FAIL rst_mid_regrant got=%b exp=01", o_gnt); end
    checks++; if (o_lat !== 4 || o_rsp !== 2'b01 || o_rdata !== rd || o_err !== 1'b0) begin
      failures++; $display("FAIL rst_mid_after got lat=%0d rsp=%b data=%0h err=%b exp lat=4 rsp=01 data=%0h err=0", o_lat, o_rsp, o_rdata, o_err, rd);
    end
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_back_to_back();
    test_random();
    test_timeout();
    test_timeout_edge();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
